// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_pkg
//  Purpose  : Shared constants, state type and rotate helpers for the DES
//             key-schedule generator.
//  Contents : KEY_W / CD_W / SUBKEY_W / ROUND_W widths, SHIFT_S[1:16]
//             per-round left-shift amounts, state_e {IDLE, RUN},
//             shift_amt(), rotl() and rotr() 28-bit rotate helpers.
//  Revision : 1.0  initial release
// ============================================================================
package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;
  localparam int ROUND_W  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Per-round left-shift amounts, indexed by FIPS round number 1..16.
  localparam logic [1:0] SHIFT_S [1:16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Shift amount for 0-based schedule index idx0 (i.e. SHIFT_S[idx0+1]).
  function automatic logic [1:0] shift_amt(input logic [ROUND_W-1:0] idx0);
    return SHIFT_S[int'(idx0) + 1];
  endfunction

  function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] x, input logic two);
    return two ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
  endfunction

  function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] x, input logic two);
    return two ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/Permuted_Choice_1.sv
`default_nettype none
// ============================================================================
//  Module   : Permuted_Choice_1
//  Purpose  : FIPS 46-3 PC-1. Selects 56 of the 64 key bits (parity bits
//             dropped) into the C||D register layout.
//  Ports    : key_i [63:0]  key, MSB-first (key_i[63] = FIPS bit 1)
//             cd_o  [55:0]  C0||D0, MSB-first (cd_o[55] = PC-1 output bit 1)
//  Revision : 1.0  initial release
// ============================================================================
module Permuted_Choice_1 (
  input  logic [63:0] key_i,
  output logic [55:0] cd_o
);

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    localparam int SRC = 64 - PC1_TAB[i];
    assign cd_o[55-i] = key_i[SRC];
  end

  // Parity bits (FIPS 8, 16, ..., 64) take no part in the schedule.
  logic w_parity_unused;
  assign w_parity_unused = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

endmodule
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
//  Module   : des_pc2
//  Purpose  : FIPS 46-3 PC-2. Compresses C||D (56 bits) into a 48-bit
//             round subkey. Purely combinational.
//  Ports    : cd_i     [55:0]  C||D, MSB-first (cd_i[55] = bit 1)
//             subkey_o [47:0]  subkey, MSB-first (subkey_o[47] = bit 1)
//  Revision : 1.0  initial release
// ============================================================================
module des_pc2 (
  input  logic [55:0] cd_i,
  output logic [47:0] subkey_o
);

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < 48; i++) begin : g_pc2
    localparam int SRC = 56 - PC2_TAB[i];
    assign subkey_o[47-i] = cd_i[SRC];
  end

  // C||D bits 9, 18, 22, 25, 35, 38, 43, 54 are not selected by PC-2.
  logic w_drop_unused;
  assign w_drop_unused = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                           cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : des_key_schedule
//  Purpose  : Sequential DES key schedule. Accepts a key over valid/ready,
//             applies PC-1, then emits NUM_ROUNDS subkeys (PC-2 of the
//             rotated C/D halves), one per accepted beat, in encrypt
//             (K1 upward) or decrypt (K16 downward) order.
//  Ports    : clk_i, rst_ni             clock, async active-low reset
//             key_valid_i/key_ready_o   key handshake
//             key_i[63:0], mode_i       key and order (1 = decrypt)
//             flush_i                   synchronous abort
//             subkey_valid_o/subkey_ready_i  subkey handshake
//             subkey_o[47:0]            PC-2 output
//             subkey_round_o[3:0]       FIPS round index minus 1
//             subkey_last_o             final subkey of this key
//  Revision : 1.0  initial release
// ============================================================================
module des_key_schedule
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                key_valid_i,
  output logic                key_ready_o,
  input  logic [KEY_W-1:0]    key_i,
  input  logic                mode_i,
  input  logic                flush_i,
  output logic                subkey_valid_o,
  input  logic                subkey_ready_i,
  output logic [SUBKEY_W-1:0] subkey_o,
  output logic [ROUND_W-1:0]  subkey_round_o,
  output logic                subkey_last_o
);

  localparam logic [ROUND_W-1:0] LAST_CNT = ROUND_W'(NUM_ROUNDS - 1);

  state_e             state_q, state_d;
  logic [CD_W-1:0]    c_half_q, c_half_d;
  logic [CD_W-1:0]    d_half_q, d_half_d;
  logic [ROUND_W-1:0] cnt_q, cnt_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               mode_q, mode_d;

  logic [55:0]        w_pc1;
  logic               w_last;
  logic [ROUND_W-1:0] w_idx0;
  logic               w_two;

  Permuted_Choice_1 u_pc1 (
    .key_i (key_i),
    .cd_o  (w_pc1)
  );

  des_pc2 u_pc2 (
    .cd_i     ({c_half_q, d_half_q}),
    .subkey_o (subkey_o)
  );

  assign w_last = (cnt_q == LAST_CNT);

  // Encrypt moving to round r+1 uses S[r+2]; decrypt leaving round r
  // undoes the left shift that produced it, S[r+1].
  assign w_idx0 = mode_q ? round_q : (round_q + 4'd1);
  assign w_two  = (shift_amt(w_idx0) == 2'd2);

  always_comb begin
    state_d  = state_q;
    c_half_d = c_half_q;
    d_half_d = d_half_q;
    cnt_d    = cnt_q;
    round_d  = round_q;
    mode_d   = mode_q;
    case (state_q)
      IDLE: begin
        if (key_valid_i && !flush_i) begin
          mode_d  = mode_i;
          cnt_d   = '0;
          state_d = RUN;
          if (mode_i) begin
            // Total shift over 16 rounds is 28, so C16D16 == C0D0.
            c_half_d = w_pc1[55:28];
            d_half_d = w_pc1[27:0];
            round_d  = 4'd15;
          end else begin
            c_half_d = rotl(w_pc1[55:28], 1'b0);
            d_half_d = rotl(w_pc1[27:0], 1'b0);
            round_d  = 4'd0;
          end
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (subkey_ready_i) begin
          if (w_last) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (mode_q) begin
              c_half_d = rotr(c_half_q, w_two);
              d_half_d = rotr(d_half_q, w_two);
              round_d  = round_q - 4'd1;
            end else begin
              c_half_d = rotl(c_half_q, w_two);
              d_half_d = rotl(d_half_q, w_two);
              round_d  = round_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      c_half_q <= '0;
      d_half_q <= '0;
      cnt_q    <= '0;
      round_q  <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_half_q <= c_half_d;
      d_half_q <= d_half_d;
      cnt_q    <= cnt_d;
      round_q  <= round_d;
      mode_q   <= mode_d;
    end
  end

  assign key_ready_o    = (state_q == IDLE);
  assign subkey_valid_o = (state_q == RUN);
  assign subkey_round_o = round_q;
  assign subkey_last_o  = w_last && (state_q == RUN);

endmodule
`default_nettype wire
